// File: rtl/rx_rd_arbiter.sv
// Round-robin arbiter sharing the gPTP rx timestamp read port among N_REQ requesters.
// Each grant reads one or two one-hot slots once valid, with a watchdog for slots that never arrive.
module rx_rd_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_vaild,
    input  logic [8*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_addr2,
    input  logic [N_REQ-1:0]     req_pair,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     resp_vaild,
    output logic                 resp_err,
    output logic [79:0]          resp_data0,
    output logic [79:0]          resp_data1,
    input  logic [7:0]           rx_gptp_rd_vaild,
    input  logic [79:0]          rx_gptp_rd_data,
    output logic [7:0]           rx_gptp_rd_addr,
    output logic                 rx_gptp_rd_ready
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT1 = 3'd1,
        S_READ1 = 3'd2,
        S_WAIT2 = 3'd3,
        S_READ2 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    addr2_q, addr2_d;
    logic          pair_q, pair_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [79:0]   w0_q, w0_d;
    logic [79:0]   w1_q, w1_d;
    logic          err_q, err_d;
    logic [79:0]   out0_q, out0_d;
    logic [79:0]   out1_q, out1_d;
    logic          oerr_q, oerr_d;

    logic          gnt_found;
    logic [IW-1:0] gnt_idx;
    logic [7:0]    sel_addr;
    logic [7:0]    sel_addr2;
    logic          sel_pair;
    logic          sel_ok;

    function automatic logic is_onehot(input logic [7:0] a);
        return (a != 8'h00) && ((a & (a - 8'h01)) == 8'h00);
    endfunction

    // First pending requester strictly after the pointer, wrapping around.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_addr  = '0;
        sel_addr2 = '0;
        sel_pair  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!gnt_found && req_vaild[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(cand);
                sel_addr  = req_addr[8*cand +: 8];
                sel_addr2 = req_addr2[8*cand +: 8];
                sel_pair  = req_pair[cand];
            end
        end
        sel_ok = is_onehot(sel_addr) &&
                 (!sel_pair || (is_onehot(sel_addr2) && (sel_addr2 != sel_addr)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            idx_q   <= '0;
            addr_q  <= '0;
            addr2_q <= '0;
            pair_q  <= 1'b0;
            cnt_q   <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            err_q   <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            addr2_q <= addr2_d;
            pair_q  <= pair_d;
            cnt_q   <= cnt_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            err_q   <= err_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        addr2_d = addr2_q;
        pair_d  = pair_q;
        cnt_d   = cnt_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    idx_d   = gnt_idx;
                    addr_d  = sel_addr;
                    addr2_d = sel_addr2;
                    pair_d  = sel_pair;
                    cnt_d   = '0;
                    w0_d    = '0;
                    w1_d    = '0;
                    err_d   = !sel_ok;
                    state_d = sel_ok ? S_WAIT1 : S_RESP;
                end
            end
            S_WAIT1, S_WAIT2: begin
                if ((rx_gptp_rd_vaild & ((state_q == S_WAIT1) ? addr_q : addr2_q)) != 8'h00) begin
                    state_d = (state_q == S_WAIT1) ? S_READ1 : S_READ2;
                end else begin
                    if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
                    if (TIMEOUT != 0 && cnt_d >= TMO) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_READ1: begin
                w0_d = rx_gptp_rd_data;
                if (pair_q) begin
                    cnt_d   = '0;
                    state_d = S_WAIT2;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_READ2: begin
                w1_d    = rx_gptp_rd_data;
                state_d = S_RESP;
            end
            S_RESP: begin
                ptr_d   = idx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Response fields are loaded on entry to RESP and then held until the next one.
        out0_d = out0_q;
        out1_d = out1_q;
        oerr_d = oerr_q;
        if (state_d == S_RESP) begin
            out0_d = w0_d;
            out1_d = w1_d;
            oerr_d = err_d;
        end
    end

    always_comb begin
        req_ready        = '0;
        resp_vaild       = '0;
        rx_gptp_rd_ready = 1'b0;
        rx_gptp_rd_addr  = 8'h00;
        if (!reset) begin
            case (state_q)
                S_IDLE:  if (gnt_found) req_ready[gnt_idx] = 1'b1;
                S_READ1: begin
                    rx_gptp_rd_ready = 1'b1;
                    rx_gptp_rd_addr  = addr_q;
                end
                S_READ2: begin
                    rx_gptp_rd_ready = 1'b1;
                    rx_gptp_rd_addr  = addr2_q;
                end
                S_RESP:  resp_vaild[idx_q] = 1'b1;
                default: ;
            endcase
        end
        resp_err   = oerr_q;
        resp_data0 = out0_q;
        resp_data1 = out1_q;
    end

endmodule
